// File: rtl/lbist_pkg.sv
// Shared types for the c432 logic-BIST run controller: FSM states, verdict
// encoding, per-state control word and default session geometry.
package lbist_pkg;

  localparam int unsigned LBIST_NUM_PATTERNS = 24;
  localparam int unsigned LBIST_FLUSH_CYC    = 4;
  localparam int unsigned LBIST_SIG_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } lbist_state_t;

  typedef enum logic [1:0] {
    VERDICT_NONE = 2'b00,
    VERDICT_PASS = 2'b01,
    VERDICT_FAIL = 2'b10
  } lbist_verdict_t;

  typedef struct packed {
    logic tpg_rst;
    logic misr_clr;
    logic bist_mode;
    logic misr_en;
    logic busy;
    logic done;
  } lbist_ctrl_t;

  // Control word to present while the FSM sits in state s; registered by
  // the sequencer together with the state so every control is a flop output.
  function automatic lbist_ctrl_t state_ctrl(input lbist_state_t s);
    lbist_ctrl_t c;
    c = '0;
    case (s)
      ST_IDLE: c.tpg_rst = 1'b1;
      ST_SEED: begin
        c.tpg_rst   = 1'b1;
        c.misr_clr  = 1'b1;
        c.bist_mode = 1'b1;
        c.busy      = 1'b1;
      end
      ST_RUN, ST_FLUSH: begin
        c.bist_mode = 1'b1;
        c.misr_en   = 1'b1;
        c.busy      = 1'b1;
      end
      ST_CHECK: begin
        c.bist_mode = 1'b1;
        c.busy      = 1'b1;
      end
      ST_DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: c.tpg_rst = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lbist_resp_window.sv
// Response-valid window for a BIST wrapper: delays the RUN-valid flag by the
// response pipeline depth and counts misses (found=0) in valid cycles.
// With LBIST_DIAG_EN defined the delayed valid flag is also exported.
module lbist_resp_window #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             kill,
  input  logic             run_vld,
  input  logic             found,
`ifdef LBIST_DIAG_EN
  output logic             resp_vld,
`endif
  output logic [CNT_W-1:0] miss_cnt
);

  logic [DEPTH-1:0] vld_pipe_q;
  logic [CNT_W-1:0] miss_q;
  logic             win_vld;

  assign win_vld  = vld_pipe_q[DEPTH-1];
  assign miss_cnt = miss_q;
`ifdef LBIST_DIAG_EN
  assign resp_vld = win_vld;
`endif

  // A killed session drops its in-flight responses so nothing is counted
  // once the controller is back in idle.
  always_ff @(posedge clk) begin
    if (!rst || clr || kill) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q <= (vld_pipe_q << 1) | DEPTH'(run_vld);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      miss_q <= '0;
    end else if (win_vld && !kill && !found && (miss_q != '1)) begin
      miss_q <= miss_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lbist_sequencer.sv
// Run controller for one c432 logic-BIST session: seed, run, flush, check.
// Optional feature macro LBIST_DIAG_EN adds first-miss diagnostics outputs.
module lbist_sequencer
  import lbist_pkg::*;
#(
  parameter int unsigned       NUM_PATTERNS = LBIST_NUM_PATTERNS,
  parameter int unsigned       FLUSH_CYC    = LBIST_FLUSH_CYC,
  parameter int unsigned       SIG_W        = LBIST_SIG_W,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG   = '0,
  parameter int unsigned       MAX_MISS     = 2,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               found,
  input  logic [SIG_W-1:0]   sig_in,
  output logic               bist_mode,
  output logic               tpg_rst,
  output logic               misr_clr,
  output logic               misr_en,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [CNT_W-1:0]   pat_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
`ifdef LBIST_DIAG_EN
  output logic [CNT_W-1:0]   first_fail_idx,
  output logic               first_fail_vld,
`endif
  output lbist_state_t       state_dbg
);

  localparam int unsigned FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  // Handshake: start is level-sampled only in IDLE; abort is honoured only
  // while a session is active (SEED..CHECK) and wins over normal sequencing.
  lbist_state_t   state_q;
  lbist_ctrl_t    ctrl_q;
  lbist_verdict_t verdict_q;
  logic [CNT_W-1:0] pat_cnt_q;
  logic [FL_W-1:0]  flush_cnt_q;
  logic             seed_go;
  logic             kill;
  logic             run_vld;
`ifdef LBIST_DIAG_EN
  logic             resp_vld;
`endif

  assign seed_go = (state_q == ST_IDLE) && start;
  assign kill    = abort && (state_q inside {ST_SEED, ST_RUN, ST_FLUSH, ST_CHECK});
  assign run_vld = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= state_ctrl(ST_IDLE);
      verdict_q   <= VERDICT_NONE;
      pat_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else if (kill) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= state_ctrl(ST_IDLE);
      verdict_q <= VERDICT_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_SEED;
            ctrl_q    <= state_ctrl(ST_SEED);
            verdict_q <= VERDICT_NONE;
            pat_cnt_q <= '0;
          end
        end
        ST_SEED: begin
          state_q <= ST_RUN;
          ctrl_q  <= state_ctrl(ST_RUN);
        end
        ST_RUN: begin
          if (pat_cnt_q == CNT_W'(NUM_PATTERNS - 1)) begin
            state_q     <= ST_FLUSH;
            ctrl_q      <= state_ctrl(ST_FLUSH);
            flush_cnt_q <= '0;
          end else begin
            pat_cnt_q <= pat_cnt_q + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FL_W'(FLUSH_CYC - 1)) begin
            state_q <= ST_CHECK;
            ctrl_q  <= state_ctrl(ST_CHECK);
          end else begin
            flush_cnt_q <= flush_cnt_q + FL_W'(1);
          end
        end
        ST_CHECK: begin
          state_q <= ST_DONE;
          ctrl_q  <= state_ctrl(ST_DONE);
          if ((sig_in == GOLDEN_SIG) && (miss_cnt <= CNT_W'(MAX_MISS))) begin
            verdict_q <= VERDICT_PASS;
          end else begin
            verdict_q <= VERDICT_FAIL;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ctrl_q  <= state_ctrl(ST_IDLE);
        end
        default: begin
          state_q <= ST_IDLE;
          ctrl_q  <= state_ctrl(ST_IDLE);
        end
      endcase
    end
  end

  lbist_resp_window #(
    .DEPTH (FLUSH_CYC),
    .CNT_W (CNT_W)
  ) u_resp_window (
    .clk      (clk),
    .rst      (rst),
    .clr      (seed_go),
    .kill     (kill),
    .run_vld  (run_vld),
    .found    (found),
`ifdef LBIST_DIAG_EN
    .resp_vld (resp_vld),
`endif
    .miss_cnt (miss_cnt)
  );

`ifdef LBIST_DIAG_EN
  // resp_idx counts valid response cycles, i.e. the RUN pattern index
  // delayed through the response pipeline.
  logic [CNT_W-1:0] resp_idx_q;
  logic [CNT_W-1:0] ff_idx_q;
  logic             ff_vld_q;

  always_ff @(posedge clk) begin
    if (!rst || seed_go) begin
      resp_idx_q <= '0;
      ff_idx_q   <= '0;
      ff_vld_q   <= 1'b0;
    end else if (resp_vld && !kill) begin
      resp_idx_q <= resp_idx_q + CNT_W'(1);
      if (!found && !ff_vld_q) begin
        ff_idx_q <= resp_idx_q;
        ff_vld_q <= 1'b1;
      end
    end
  end

  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;
`endif

  assign tpg_rst   = ctrl_q.tpg_rst;
  assign misr_clr  = ctrl_q.misr_clr;
  assign bist_mode = ctrl_q.bist_mode;
  assign misr_en   = ctrl_q.misr_en;
  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign pass      = (verdict_q == VERDICT_PASS);
  assign fail      = (verdict_q == VERDICT_FAIL);
  assign pat_cnt   = pat_cnt_q;
  assign state_dbg = state_q;

endmodule
